ladder_sched: RTL and testbench
===============================

LADDER_SCHED -- requirements
Module: ladder_sched

Interface
REQ-001 Parameter N, default 233: scalar and field width.
REQ-002 Parameter TIMEOUT, default 4095: watchdog limit in cycles per sub-operation.
REQ-003 CLK  in  1  single clock; all state changes on rising edge.
REQ-004 RST  in  1  reset, asynchronous, active-high.
REQ-005 IN_VALID  in  1  start strobe; K sampled on the same cycle.
REQ-006 K  in  N  scalar multiplier.
REQ-007 TRANS_START/STEP_START/CONV_START  out  1 each  single-cycle start pulses to the translate, ladder-step and coordinate-conversion units.
REQ-008 STEP_BIT  out  1  current scalar bit k[i]; stable while the step runs.
REQ-009 TRANS_DONE/STEP_DONE/CONV_DONE  in  1 each  completion pulses from the three units.
REQ-010 UNIT_ERROR  in  1  fault flag from the multiplier or any unit.
REQ-011 BUSY  out  1  high in every state except IDLE.
REQ-012 OUT_VALID, OUT_ZERO, OUT_ERROR  out  1 each  single-cycle completion, point-at-infinity and abort flags.

Function
REQ-013 States: IDLE, SCAN, TRANS, STEP, CONV, DONE, ERR.
REQ-014 IDLE: on IN_VALID, latch K, set index i=N-1, go to SCAN; IN_VALID in any other state is ignored.
REQ-015 SCAN: one bit per cycle; if K[i]=1, go to TRANS with i-1 as the next step index; else decrement i; K=0 reaches i=0 with K[0]=0, then goes to DONE with OUT_ZERO.
REQ-016 TRANS: TRANS_START pulses on the entry cycle; wait for TRANS_DONE.
REQ-017 On TRANS_DONE: if the leading one was bit 0, go to CONV; else go to STEP.
REQ-018 STEP: STEP_START pulses on the entry cycle with STEP_BIT=K[i]; on STEP_DONE, if i=0 go to CONV, else decrement i and re-enter STEP.
REQ-019 CONV: CONV_START pulses on the entry cycle; on CONV_DONE go to DONE.
REQ-020 DONE: OUT_VALID=1 for one cycle (OUT_ZERO=1 too on the K=0 path); return to IDLE next cycle.
REQ-021 UNIT_ERROR high in TRANS, STEP or CONV: go to ERR; OUT_ERROR=1 for one cycle; go to IDLE; no OUT_VALID.
REQ-022 A done pulse that does not match the current state is ignored.
REQ-023 A done pulse on the same cycle as UNIT_ERROR: the error wins.
REQ-024 Step count is exactly (index of the leading one of K).

Reset
REQ-025 RST asserted: go to IDLE immediately and clear i, the latched K and the watchdog.
REQ-026 While RST is asserted, all outputs are 0, including STEP_BIT.
REQ-027 Reset mid-operation discards the operation; no completion flag is produced.

Configuration
REQ-028 LADDER_TIMEOUT_EN defined:
- A watchdog counts cycles in TRANS/STEP/CONV and clears on each state entry.
- When the count reaches TIMEOUT, the block behaves as on UNIT_ERROR.
REQ-029 LADDER_TIMEOUT_EN undefined: no watchdog logic; the block waits indefinitely.

Structure
REQ-030 The shared package ecc_pkg holds N, the state enumeration and the TIMEOUT default.
REQ-031 One sub-module, ladder_bit_cnt: the loadable down-counter for i with a zero flag.

Verification
REQ-032 Zero scalar: K=0 -> N+1 cycles after IN_VALID, OUT_VALID=1 and OUT_ZERO=1; no start pulses.
REQ-033 Unit scalar: K=1 -> TRANS_START, then CONV_START; zero STEP_START; then OUT_VALID.
REQ-034 K=0xB:
- STEP_START occurs 3 times, with STEP_BIT=0,1,1.
- Then CONV_START, then OUT_VALID.
REQ-035 K=0xB with UNIT_ERROR during the second step -> OUT_ERROR pulse, BUSY=0 next cycle, no CONV_START.
REQ-036 RST asserted during the second STEP -> all outputs 0 immediately; a new IN_VALID with K=2 gives 1 step with STEP_BIT=0.
REQ-037 With LADDER_TIMEOUT_EN and TIMEOUT=16, TRANS_DONE withheld -> OUT_ERROR 16 cycles after TRANS_START.

Source files
------------

// File: rtl/ecc_pkg.sv
// Shared definitions for the scalar-multiplication ladder scheduler:
// default field width, default watchdog limit, FSM state encoding and a
// small width helper for index counters.
package ecc_pkg;

  // Default scalar / field width.
  localparam int ECC_N = 233;

  // Default watchdog limit in cycles per sub-operation.
  localparam int ECC_TIMEOUT = 4095;

  // Scheduler states.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SCAN  = 3'd1,
    S_TRANS = 3'd2,
    S_STEP  = 3'd3,
    S_CONV  = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  // Bits needed to hold an index in 0..n-1 (at least one bit).
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ladder_bit_cnt.sv
// Loadable down-counter holding the current scalar bit index.
// Decrement saturates at zero; zero flag is decoded from the register.
module ladder_bit_cnt
  import ecc_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: load has priority over decrement; never wraps below zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Index register, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);

endmodule

// File: rtl/ladder_sched.sv
// Montgomery-ladder scheduler: scans the scalar from the top bit for the
// leading one, then sequences translate, one ladder step per remaining bit,
// and the final coordinate conversion, reporting completion, zero scalar or
// abort.
// Optional build macro LADDER_TIMEOUT_EN adds a per-sub-operation watchdog
// that aborts after TIMEOUT cycles in TRANS/STEP/CONV; without it the block
// waits indefinitely for the unit done pulses.
//
// Handshake: in_valid is accepted only in IDLE (single-cycle strobe, k sampled
// with it); *_start are one-cycle pulses on the first cycle of the matching
// state; *_done pulses are honoured only in the matching state, unit_error
// takes priority over any done in the same cycle.
module ladder_sched
  import ecc_pkg::*;
#(
  parameter int N       = ECC_N,
  parameter int TIMEOUT = ECC_TIMEOUT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [N-1:0] k,
  output logic         trans_start,
  output logic         step_start,
  output logic         conv_start,
  output logic         step_bit,
  input  logic         trans_done,
  input  logic         step_done,
  input  logic         conv_done,
  input  logic         unit_error,
  output logic         busy,
  output logic         out_valid,
  output logic         out_zero,
  output logic         out_error,
  output state_t       state_dbg
);

  localparam int IW = idx_w(N);
  localparam logic [IW-1:0] TOP_IDX = IW'(N - 1);

  state_t       state_q, state_d;
  logic [N-1:0] k_q, k_d;
  logic         kzero_q, kzero_d;
  logic         lead0_q, lead0_d;
  logic         trans_start_q, trans_start_d;
  logic         step_start_q, step_start_d;
  logic         conv_start_q, conv_start_d;

  logic          cnt_load;
  logic          cnt_dec;
  logic [IW-1:0] idx;
  logic          idx_zero;
  logic          cur_bit;
  logic          abort;

  ladder_bit_cnt #(.W(IW)) u_bit_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (TOP_IDX),
    .dec      (cnt_dec),
    .cnt      (idx),
    .zero     (idx_zero)
  );

  assign cur_bit = k_q[idx];

`ifdef LADDER_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT + 1);

  logic [WW-1:0] wdog_q, wdog_d;
  logic          wdog_active;
  logic          wdog_hit;

  assign wdog_active = (state_q == S_TRANS) || (state_q == S_STEP) ||
                       (state_q == S_CONV);
  // Entry cycle holds 0, so the hit lands TIMEOUT cycles after the start pulse.
  assign wdog_hit    = wdog_active && (wdog_q == WW'(TIMEOUT - 1));
  assign abort       = unit_error || wdog_hit;

  // Watchdog restarts on every sub-operation entry and idles outside them.
  always_comb begin
    wdog_d = '0;
    if (trans_start_d || step_start_d || conv_start_d) begin
      wdog_d = '0;
    end else if (wdog_active) begin
      wdog_d = wdog_q + 1'b1;
    end
  end

  // Watchdog register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`else
  assign abort = unit_error;
`endif

  // Next-state, scalar latch, index control and start-pulse generation.
  always_comb begin
    state_d       = state_q;
    k_d           = k_q;
    kzero_d       = kzero_q;
    lead0_d       = lead0_q;
    trans_start_d = 1'b0;
    step_start_d  = 1'b0;
    conv_start_d  = 1'b0;
    cnt_load      = 1'b0;
    cnt_dec       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          k_d      = k;
          kzero_d  = 1'b0;
          lead0_d  = 1'b0;
          cnt_load = 1'b1;
          state_d  = S_SCAN;
        end
      end
      S_SCAN: begin
        if (cur_bit) begin
          // Leading one found; the index moves on to the first step bit.
          lead0_d       = idx_zero;
          cnt_dec       = !idx_zero;
          trans_start_d = 1'b1;
          state_d       = S_TRANS;
        end else if (idx_zero) begin
          kzero_d = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      S_TRANS: begin
        if (abort) begin
          state_d = S_ERR;
        end else if (trans_done) begin
          if (lead0_q) begin
            conv_start_d = 1'b1;
            state_d      = S_CONV;
          end else begin
            step_start_d = 1'b1;
            state_d      = S_STEP;
          end
        end
      end
      S_STEP: begin
        if (abort) begin
          state_d = S_ERR;
        end else if (step_done) begin
          if (idx_zero) begin
            conv_start_d = 1'b1;
            state_d      = S_CONV;
          end else begin
            cnt_dec      = 1'b1;
            step_start_d = 1'b1;
          end
        end
      end
      S_CONV: begin
        if (abort) begin
          state_d = S_ERR;
        end else if (conv_done) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, scalar and start-pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      k_q           <= '0;
      kzero_q       <= 1'b0;
      lead0_q       <= 1'b0;
      trans_start_q <= 1'b0;
      step_start_q  <= 1'b0;
      conv_start_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      k_q           <= k_d;
      kzero_q       <= kzero_d;
      lead0_q       <= lead0_d;
      trans_start_q <= trans_start_d;
      step_start_q  <= step_start_d;
      conv_start_q  <= conv_start_d;
    end
  end

  assign trans_start = trans_start_q;
  assign step_start  = step_start_q;
  assign conv_start  = conv_start_q;
  assign step_bit    = (state_q == S_STEP) && cur_bit;
  assign busy        = (state_q != S_IDLE);
  assign out_valid   = (state_q == S_DONE);
  assign out_zero    = (state_q == S_DONE) && kzero_q;
  assign out_error   = (state_q == S_ERR);
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_ladder_sched.sv
// Bench for ladder_sched: a responding unit model answers start pulses with
// done pulses after a random delay, a monitor records every start/completion
// event, and each test compares recorded events against expected ones.
module tb_ladder_sched;
  import ecc_pkg::*;

  localparam int N = ECC_N;
`ifdef LADDER_TIMEOUT_EN
  localparam int TB_TIMEOUT = 16;
`else
  localparam int TB_TIMEOUT = ECC_TIMEOUT;
`endif

  localparam logic [2:0] EV_TRANS  = 3'd1;
  localparam logic [2:0] EV_STEP0  = 3'd2;
  localparam logic [2:0] EV_STEP1  = 3'd3;
  localparam logic [2:0] EV_CONV   = 3'd4;
  localparam logic [2:0] EV_VALID  = 3'd5;
  localparam logic [2:0] EV_ZVALID = 3'd6;
  localparam logic [2:0] EV_ERROR  = 3'd7;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [N-1:0] k;
  logic         trans_start, step_start, conv_start, step_bit;
  logic         trans_done, step_done, conv_done, unit_error;
  logic         busy, out_valid, out_zero, out_error;
  state_t       state_dbg;

  logic [2:0] exp_q[$];
  logic [2:0] obs_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t0    = 0;
  int trans_cyc = 0;
  int valid_cyc = 0;
  int err_cyc   = 0;

  // responder controls
  bit resp_en    = 1'b1;
  bit spur_en    = 1'b0;
  bit err_trans  = 1'b0;
  int err_step_n = 0;
  int step_cnt_r = 0;

  ladder_sched #(.N(N), .TIMEOUT(TB_TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .k           (k),
    .trans_start (trans_start),
    .step_start  (step_start),
    .conv_start  (conv_start),
    .step_bit    (step_bit),
    .trans_done  (trans_done),
    .step_done   (step_done),
    .conv_done   (conv_done),
    .unit_error  (unit_error),
    .busy        (busy),
    .out_valid   (out_valid),
    .out_zero    (out_zero),
    .out_error   (out_error),
    .state_dbg   (state_dbg)
  );

  // clock / reset / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #800000;
    $display("FAIL global_timeout: sim time exceeded limit, want completion");
    $fatal(1);
  end

  function automatic logic [7:0] outs_vec();
    return {trans_start, step_start, conv_start, step_bit,
            busy, out_valid, out_zero, out_error};
  endfunction

  // unit model: answers each start pulse after 0..3 cycles
  initial begin
    trans_done = 1'b0; step_done = 1'b0; conv_done = 1'b0; unit_error = 1'b0;
    forever begin
      int kind;
      int dly;
      @(negedge clk);
      trans_done = 1'b0; step_done = 1'b0; conv_done = 1'b0; unit_error = 1'b0;
      if (resp_en && !rst && (trans_start || step_start || conv_start)) begin
        kind = trans_start ? 0 : (step_start ? 1 : 2);
        if (kind == 1) step_cnt_r++;
        dly = $urandom_range(0, 3);
        repeat (dly) @(negedge clk);
        case (kind)
          0:       trans_done = 1'b1;
          1:       step_done  = 1'b1;
          default: conv_done  = 1'b1;
        endcase
        if (spur_en) begin
          trans_done = 1'b1; step_done = 1'b1; conv_done = 1'b1;
        end
        if (kind == 1 && err_step_n == step_cnt_r) begin
          step_done  = 1'b0;
          unit_error = 1'b1;
        end
        if (kind == 0 && err_trans) unit_error = 1'b1;
      end
    end
  end

  // monitor: records observed events
  always @(negedge clk) begin
    if (!rst) begin
      if (trans_start) begin obs_q.push_back(EV_TRANS); trans_cyc = cyc; end
      if (step_start)  obs_q.push_back(step_bit ? EV_STEP1 : EV_STEP0);
      if (conv_start)  obs_q.push_back(EV_CONV);
      if (out_valid) begin
        obs_q.push_back(out_zero ? EV_ZVALID : EV_VALID);
        valid_cyc = cyc;
      end
      if (out_error) begin obs_q.push_back(EV_ERROR); err_cyc = cyc; end
    end
  end

  // reference model: expected event sequence for one clean operation
  task automatic model_op(input logic [N-1:0] kv);
    int lead;
    lead = -1;
    for (int b = N - 1; b >= 0; b--) begin
      if (lead < 0 && kv[b]) lead = b;
    end
    if (lead < 0) begin
      exp_q.push_back(EV_ZVALID);
    end else begin
      exp_q.push_back(EV_TRANS);
      for (int b = lead - 1; b >= 0; b--) exp_q.push_back(kv[b] ? EV_STEP1 : EV_STEP0);
      exp_q.push_back(EV_CONV);
      exp_q.push_back(EV_VALID);
    end
  endtask

  // driver: start one operation, wait for completion or error (bounded)
  task automatic run_op(input logic [N-1:0] kv, input int budget,
                        input int extra_at, output bit to);
    step_cnt_r = 0;
    @(negedge clk);
    in_valid = 1'b1;
    k        = kv;
    t0       = cyc;
    to       = 1'b1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      in_valid = (c == extra_at);
      if (c == extra_at) k = ~kv;
      if (out_valid || out_error) begin
        to = 1'b0;
        break;
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; k = '1;
    repeat (3) @(negedge clk);
    total++;
    if (outs_vec() !== 8'h00) begin
      bad++; $display("FAIL reset_outs: got %b want 00000000", outs_vec());
    end
    total++;
    if (state_dbg !== S_IDLE) begin
      bad++; $display("FAIL reset_state: got %0d want %0d", state_dbg, S_IDLE);
    end
    rst = 1'b0; in_valid = 1'b0; k = '0;
    repeat (2) @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL reset_idle_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_zero();
    logic [2:0] e, o;
    bit to;
    model_op('0);
    run_op('0, 2000, -1, to);
    total++;
    if (to) begin bad++; $display("FAIL zero_wait: got timeout want completion"); end
    total++;
    if (valid_cyc - t0 !== N + 1) begin
      bad++; $display("FAIL zero_latency: got %0d want %0d", valid_cyc - t0, N + 1);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin bad++; $display("FAIL zero_evt: got none want %0d", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin bad++; $display("FAIL zero_evt: got %0d want %0d", o, e); end
      end
    end
    total++;
    if (obs_q.size() != 0) begin
      bad++; $display("FAIL zero_extra: got %0d events want 0", obs_q.size()); obs_q.delete();
    end
  endtask

  // directed scalars: unit scalar, 0xB, two-bit scalar, top bit set
  task automatic test_directed();
    logic [2:0] e, o;
    logic [N-1:0] kv;
    bit to;
    for (int t = 0; t < 4; t++) begin
      kv = '0;
      case (t)
        0: kv[0] = 1'b1;
        1: kv[3:0] = 4'hB;
        2: kv[1] = 1'b1;
        default: begin kv[N-1] = 1'b1; kv[5] = 1'b1; kv[0] = 1'b1; end
      endcase
      model_op(kv);
      run_op(kv, 4000, -1, to);
      total++;
      if (to) begin bad++; $display("FAIL dir_wait[%0d]: got timeout want completion", t); end
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); total++;
        if (obs_q.size() == 0) begin bad++; $display("FAIL dir_evt[%0d]: got none want %0d", t, e); end
        else begin
          o = obs_q.pop_front();
          if (o !== e) begin bad++; $display("FAIL dir_evt[%0d]: got %0d want %0d", t, o, e); end
        end
      end
      total++;
      if (obs_q.size() != 0) begin
        bad++; $display("FAIL dir_extra[%0d]: got %0d want 0", t, obs_q.size()); obs_q.delete();
      end
    end
  endtask

  task automatic test_random();
    logic [2:0] e, o;
    logic [N-1:0] kv, tmp, one, mask;
    int lead;
    bit to;
    one = 1;
    for (int t = 0; t < 6; t++) begin
      kv = '0;
      for (int w = 0; w < N; w += 32) begin
        tmp = '0; tmp[31:0] = $urandom; kv |= tmp << w;
      end
      lead = $urandom_range(0, 14);
      mask = (one << (lead + 1)) - one;
      kv   = (kv & mask) | (one << lead);
      model_op(kv);
      run_op(kv, 2000, -1, to);
      total++;
      if (to) begin bad++; $display("FAIL rand_wait[%0d]: got timeout want completion", t); end
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); total++;
        if (obs_q.size() == 0) begin bad++; $display("FAIL rand_evt[%0d]: got none want %0d", t, e); end
        else begin
          o = obs_q.pop_front();
          if (o !== e) begin bad++; $display("FAIL rand_evt[%0d]: got %0d want %0d", t, o, e); end
        end
      end
      total++;
      if (obs_q.size() != 0) begin
        bad++; $display("FAIL rand_extra[%0d]: got %0d want 0", t, obs_q.size()); obs_q.delete();
      end
    end
  endtask

  // in_valid while busy and mismatched done pulses are both ignored
  task automatic test_ignored_inputs();
    logic [2:0] e, o;
    logic [N-1:0] kv;
    bit to;
    kv = '0; kv[3:0] = 4'hB;
    spur_en = 1'b1;
    model_op(kv);
    run_op(kv, 2000, 240, to);
    spur_en = 1'b0;
    total++;
    if (to) begin bad++; $display("FAIL ign_wait: got timeout want completion"); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin bad++; $display("FAIL ign_evt: got none want %0d", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin bad++; $display("FAIL ign_evt: got %0d want %0d", o, e); end
      end
    end
    total++;
    if (obs_q.size() != 0) begin
      bad++; $display("FAIL ign_extra: got %0d want 0", obs_q.size()); obs_q.delete();
    end
  endtask

  // unit error in the second step, then error coinciding with trans_done
  task automatic test_error();
    logic [2:0] e, o;
    logic [N-1:0] kv;
    bit to;
    kv = '0; kv[3:0] = 4'hB;
    err_step_n = 2;
    exp_q.push_back(EV_TRANS); exp_q.push_back(EV_STEP0);
    exp_q.push_back(EV_STEP1); exp_q.push_back(EV_ERROR);
    run_op(kv, 2000, -1, to);
    err_step_n = 0;
    total++;
    if (to) begin bad++; $display("FAIL err_wait: got timeout want error"); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL err_busy: got %b want 0", busy); end
    kv = '0; kv[0] = 1'b1;
    err_trans = 1'b1;
    exp_q.push_back(EV_TRANS); exp_q.push_back(EV_ERROR);
    run_op(kv, 2000, -1, to);
    err_trans = 1'b0;
    total++;
    if (to) begin bad++; $display("FAIL errwin_wait: got timeout want error"); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin bad++; $display("FAIL err_evt: got none want %0d", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin bad++; $display("FAIL err_evt: got %0d want %0d", o, e); end
      end
    end
    total++;
    if (obs_q.size() != 0) begin
      bad++; $display("FAIL err_extra: got %0d want 0", obs_q.size()); obs_q.delete();
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] e, o;
    logic [N-1:0] kv;
    int n;
    bit found, to;
    kv = '0; kv[3:0] = 4'hB;
    step_cnt_r = 0;
    @(negedge clk); in_valid = 1'b1; k = kv;
    @(negedge clk); in_valid = 1'b0;
    n = 0; found = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (step_start) n++;
      if (n == 2) begin found = 1'b1; break; end
    end
    total++;
    if (!found) begin bad++; $display("FAIL rmid_reach: got %0d steps want 2", n); end
    rst = 1'b1;
    #1;
    total++;
    if (outs_vec() !== 8'h00) begin
      bad++; $display("FAIL rmid_outs: got %b want 00000000", outs_vec());
    end
    repeat (5) @(negedge clk);
    rst = 1'b0;
    obs_q.delete(); exp_q.delete();
    repeat (4) @(negedge clk);
    total++;
    if (obs_q.size() != 0 || busy !== 1'b0) begin
      bad++; $display("FAIL rmid_discard: got %0d events busy=%b want 0 events busy=0", obs_q.size(), busy);
      obs_q.delete();
    end
    kv = '0; kv[1] = 1'b1;
    model_op(kv);
    run_op(kv, 2000, -1, to);
    total++;
    if (to) begin bad++; $display("FAIL rmid_wait: got timeout want completion"); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin bad++; $display("FAIL rmid_evt: got none want %0d", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin bad++; $display("FAIL rmid_evt: got %0d want %0d", o, e); end
      end
    end
    total++;
    if (obs_q.size() != 0) begin
      bad++; $display("FAIL rmid_extra: got %0d want 0", obs_q.size()); obs_q.delete();
    end
  endtask

  // withheld trans_done: watchdog abort when enabled, indefinite wait otherwise
  task automatic test_timeout();
    logic [2:0] e, o;
    logic [N-1:0] kv;
    bit to;
    kv = '0; kv[0] = 1'b1;
    resp_en = 1'b0;
`ifdef LADDER_TIMEOUT_EN
    exp_q.push_back(EV_TRANS); exp_q.push_back(EV_ERROR);
    run_op(kv, 1000, -1, to);
    total++;
    if (to) begin bad++; $display("FAIL tmo_wait: got timeout want error"); end
    total++;
    if (err_cyc - trans_cyc !== 16) begin
      bad++; $display("FAIL tmo_latency: got %0d want 16", err_cyc - trans_cyc);
    end
`else
    exp_q.push_back(EV_TRANS);
    run_op(kv, 600, -1, to);
    total++;
    if (!to || busy !== 1'b1 || state_dbg !== S_TRANS) begin
      bad++; $display("FAIL hold_wait: got done=%b busy=%b state=%0d want still in TRANS", !to, busy, state_dbg);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
`endif
    resp_en = 1'b1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin bad++; $display("FAIL tmo_evt: got none want %0d", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin bad++; $display("FAIL tmo_evt: got %0d want %0d", o, e); end
      end
    end
    total++;
    if (obs_q.size() != 0) begin
      bad++; $display("FAIL tmo_extra: got %0d want 0", obs_q.size()); obs_q.delete();
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; k = '0;
    test_reset();
    test_zero();
    test_directed();
    test_random();
    test_ignored_inputs();
    test_error();
    test_reset_mid();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
